// File: rtl/cache_request_sequencer.sv
// Processor-side request sequencer: queues read/write commands, issues each to the cache
// controller as a one-cycle request, and returns one response per command. Optional: CACHE_REQ_TIMEOUT_EN.
module cache_request_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int CMD_DEPTH      = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  read_request,
  output logic                  write_request,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  ready,
  input  logic                  hit_signal,
  input  logic                  miss_signal,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  rsp_error,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic                  busy
);

  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state_q, state_d;
  cmd_t                  mem_q [CMD_DEPTH];
  cmd_t                  mem_d [CMD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]     count_q, count_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  miss_q, miss_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic                  push, pop, timeout;
  logic                  rsp_err_now;

`ifdef CACHE_REQ_TIMEOUT_EN
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  rsp_error_q, rsp_error_d;
  assign timeout     = (state_q == WAIT) && !hit_signal &&
                       (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err_now = rsp_error_q;
  assign rsp_error   = rsp_error_q;
`else
  logic [WAIT_W-1:0]     unused_timeout_cfg;
  assign unused_timeout_cfg = WAIT_W'(TIMEOUT_CYCLES);
  assign timeout     = 1'b0;
  assign rsp_err_now = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   if (ready) state_d = WAIT;
      WAIT:    if (hit_signal || timeout) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: requests follow ready combinationally so a stalled ISSUE never pulses
  always_comb begin
    read_request  = 1'b0;
    write_request = 1'b0;
    if (state_q == ISSUE && ready) begin
      read_request  = !cmd_q.write;
      write_request = cmd_q.write;
    end
    cmd_ready = (count_q != CNT_FW'(CMD_DEPTH));
    busy      = (state_q != IDLE) || (count_q != '0);
  end

  assign address    = cmd_q.addr;
  assign write_data = cmd_q.wdata;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_hit    = rsp_hit_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Datapath: FIFO, command register, response capture, statistics
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cmd_d        = cmd_q;
    miss_d       = miss_q;
    rsp_valid_d  = 1'b0;
    rsp_write_d  = rsp_write_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_data_d   = rsp_data_q;
    rsp_hit_d    = rsp_hit_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
`ifdef CACHE_REQ_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    rsp_error_d  = rsp_error_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      cmd_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      miss_d   = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
`ifdef CACHE_REQ_TIMEOUT_EN
      ISSUE: if (ready) wait_cnt_d = '0;
`endif
      WAIT: begin
        if (miss_signal) miss_d = 1'b1;
`ifdef CACHE_REQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
        if (hit_signal) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_addr_d  = cmd_q.addr;
          rsp_data_d  = cmd_q.write ? '0 : read_data;
          // A miss arriving alongside the completion still counts as a miss
          rsp_hit_d   = !(miss_q || miss_signal);
`ifdef CACHE_REQ_TIMEOUT_EN
          rsp_error_d = 1'b0;
`endif
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_addr_d  = cmd_q.addr;
          rsp_data_d  = '0;
          rsp_hit_d   = 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
          rsp_error_d = 1'b1;
`endif
        end
      end
      RESPOND: begin
        if (!rsp_err_now) begin
          if (rsp_hit_q) begin
            if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_WIDTH'(1);
          end else begin
            if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_q        <= '0;
      miss_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
      rsp_hit_q    <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rsp_error_q  <= 1'b0;
`endif
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      miss_q       <= miss_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_hit_q    <= rsp_hit_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`ifdef CACHE_REQ_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      rsp_error_q  <= rsp_error_d;
`endif
    end
  end

endmodule
